// File: rtl/slot_tx.sv
// Byte-wide TX FIFO feeding an 8N1 serial framer. Each bit advances on a rising
// edge of the G_CLK_TX slot clock, which is sampled as a level in the SYS_CLK domain.
module slot_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     SYS_CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     G_CLK_TX,
    input  logic                     ovf_clr,
    output logic                     tx_serial,
    output logic                     tx_active,
    output logic                     tx_done,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          g_q;
    logic          bit_tick;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic [1:0]    state;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign bit_tick   = G_CLK_TX & ~g_q;
    assign fifo_level = count;
    assign fifo_full  = (count == FULL_LVL);
    assign fifo_empty = (count == '0);
    assign dbg_state  = state;

    // A pop only happens where a new frame starts, so a full FIFO can still accept a write then.
    assign pop     = bit_tick & ~fifo_empty & ((state == IDLE) | (state == STOP));
    assign push    = wr_en & (~fifo_full | pop);
    assign ovf_set = wr_en & fifo_full & ~pop;

    always_ff @(posedge SYS_CLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            g_q       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            state     <= IDLE;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            g_q     <= G_CLK_TX;
            tx_done <= 1'b0;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (bit_tick) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            shreg     <= mem[rd_ptr];
                            state     <= START;
                            tx_serial <= 1'b0;
                            tx_active <= 1'b1;
                        end
                    end
                    START: begin
                        state     <= DATA;
                        bit_idx   <= 3'd0;
                        tx_serial <= shreg[0];
                    end
                    DATA: begin
                        if (bit_idx != 3'd7) begin
                            shreg     <= shreg >> 1;
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= shreg[1];
                        end else begin
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end
                    end
                    default: begin
                        tx_done <= 1'b1;
                        if (pop) begin
                            shreg     <= mem[rd_ptr];
                            state     <= START;
                            tx_serial <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            tx_serial <= 1'b1;
                            tx_active <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_slot_tx.sv
// Bench for slot_tx: a queue plus bit-slot-position model checked every cycle,
// directed frame/overflow/reset scenarios, then a randomized soak.
module tb_slot_tx;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'd0;
    logic          G_CLK_TX = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          tx_serial;
    logic          tx_active;
    logic          tx_done;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    slot_tx #(.DEPTH(DEPTH)) dut (
        .SYS_CLK(clk), .RST(RST), .wr_en(wr_en), .wr_data(wr_data),
        .G_CLK_TX(G_CLK_TX), .ovf_clr(ovf_clr), .tx_serial(tx_serial),
        .tx_active(tx_active), .tx_done(tx_done), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: queued bytes plus the line slot of the frame in flight
    // (0 idle, 1 start bit, 2..9 data bits LSB first, 10 stop bit).
    logic [7:0] m_q[$];
    int         m_pos = 0;
    logic [7:0] m_byte = 8'd0;
    bit         m_g = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_done = 1'b0;

    task automatic model_cycle(input bit wr, input logic [7:0] d, input bit g, input bit clr, input bit rst);
        bit tick, full, pop;
        if (rst) begin
            m_q.delete();
            m_pos = 0; m_g = 0; m_ovf = 0; m_done = 0;
        end else begin
            tick = g && !m_g;
            m_g = g;
            m_done = 0;
            full = (m_q.size() == DEPTH);
            pop = tick && (m_q.size() != 0) && (m_pos == 0 || m_pos == 10);
            if (wr && full && !pop) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (tick) begin
                if (m_pos == 10) m_done = 1;
                if (pop) begin
                    m_byte = m_q.pop_front();
                    m_pos = 1;
                end else if (m_pos == 10) m_pos = 0;
                else if (m_pos != 0) m_pos++;
            end
            if (wr && (!full || pop)) m_q.push_back(d);
        end
    endtask

    function automatic bit m_line();
        if (m_pos == 0 || m_pos == 10) return 1'b1;
        if (m_pos == 1) return 1'b0;
        return m_byte[m_pos-2];
    endfunction

    task automatic step(input bit wr, input logic [7:0] d, input bit g, input bit clr, input bit rst);
        @(negedge clk);
        wr_en = wr; wr_data = d; G_CLK_TX = g; ovf_clr = clr; RST = rst;
        @(posedge clk);
        model_cycle(wr, d, g, clr, rst);
        #1;
        if (tx_done === 1'b1) done_cnt++;
        check("serial",   32'(tx_serial),  32'(m_line()));
        check("active",   32'(tx_active),  32'(m_pos != 0));
        check("done",     32'(tx_done),    32'(m_done));
        check("level",    32'(fifo_level), 32'(m_q.size()));
        check("full",     32'(fifo_full),  32'(m_q.size() == DEPTH));
        check("empty",    32'(fifo_empty), 32'(m_q.size() == 0));
        check("overflow", 32'(overflow),   32'(m_ovf));
    endtask

    // One slot-clock pulse; returns the line level and activity right after the tick.
    task automatic pulse(output bit s, output bit a);
        step(0, 8'd0, 1, 0, 0);
        s = tx_serial;
        a = tx_active;
        step(0, 8'd0, 0, 0, 0);
    endtask

    initial begin
        bit s, a, act_all, g_lvl;
        logic [9:0]  seq10;
        logic [19:0] seq20;

        // Reset state
        step(0, 8'd0, 0, 0, 1);
        step(0, 8'd0, 0, 0, 1);
        check("rst_serial", 32'(tx_serial), 32'd1);
        check("rst_active", 32'(tx_active), 32'd0);
        check("rst_level",  32'(fifo_level), 32'd0);
        check("rst_empty",  32'(fifo_empty), 32'd1);
        check("rst_full",   32'(fifo_full),  32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);
        step(0, 8'd0, 0, 0, 0);

        // Single frame of 0xA5
        step(1, 8'hA5, 0, 0, 0);
        done_cnt = 0;
        seq10 = '0;
        for (int i = 0; i < 10; i++) begin
            pulse(s, a);
            seq10 = {seq10[8:0], s};
        end
        check("a5_seq", 32'(seq10), 32'(10'b0101001011));
        pulse(s, a);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_empty", 32'(fifo_empty), 32'd1);
        check("a5_idle", 32'(tx_active), 32'd0);

        // Back-to-back frames 0x01 then 0x80
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h80, 0, 0, 0);
        done_cnt = 0;
        seq20 = '0;
        act_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pulse(s, a);
            seq20 = {seq20[18:0], s};
            act_all = act_all & a;
        end
        check("b2b_seq", 32'(seq20), 32'(20'b0100000001_0000000011));
        check("b2b_active", 32'(act_all), 32'd1);
        pulse(s, a);
        check("b2b_done_cnt", 32'(done_cnt), 32'd2);

        // Overflow on the fifth write, then clear
        for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        step(0, 8'd0, 0, 1, 0);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO, STOP slot: tick and write in the same cycle
        pulse(s, a);
        step(1, 8'h55, 0, 0, 0);
        for (int i = 0; i < 9; i++) pulse(s, a);
        step(1, 8'h66, 1, 0, 0);
        check("stop_level", 32'(fifo_level), 32'd4);
        check("stop_ovf", 32'(overflow), 32'd0);
        check("stop_done", 32'(tx_done), 32'd1);
        step(0, 8'd0, 0, 0, 0);
        // Drain so every queued byte, never the dropped one, is checked on the line
        for (int i = 0; i < 45; i++) pulse(s, a);
        check("drain_empty", 32'(fifo_empty), 32'd1);

        // G_CLK_TX held high gives a single tick
        step(0, 8'd0, 0, 0, 1);
        step(1, 8'h3C, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 8'd0, 1, 0, 0);
        check("hold_active", 32'(tx_active), 32'd1);
        check("hold_serial", 32'(tx_serial), 32'd0);
        check("hold_level", 32'(fifo_level), 32'd0);
        step(0, 8'd0, 0, 0, 0);

        // Reset mid-frame
        step(0, 8'd0, 0, 0, 1);
        step(1, 8'hC3, 0, 0, 0);
        step(1, 8'h5A, 0, 0, 0);
        for (int i = 0; i < 5; i++) pulse(s, a);
        step(0, 8'd0, 0, 0, 1);
        check("midrst_serial", 32'(tx_serial), 32'd1);
        check("midrst_active", 32'(tx_active), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);

        // Randomized soak
        g_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bit wr, clr, rst;
            rst = ($urandom_range(0, 599) == 0);
            wr  = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) g_lvl = ~g_lvl;
            step(wr, 8'($urandom_range(0, 255)), g_lvl, clr, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
